alu_seq: RTL and testbench

- Parametrised N-bit registered ALU. It is the word-level successor of the 1-bit ALU slice and keeps the same 3-bit operation encoding.
- Adds carry, overflow and zero flags, signed set-less-than, and a multi-cycle unsigned shift-add multiply.
- Uses a start/busy/done handshake so a control FSM can issue operations and wait for completion.

---
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 tb/tb_alu_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered N-bit ALU with carry/overflow/zero flags, signed
// set-less-than and a multi-cycle unsigned shift-add multiplier.
// Single-cycle ops complete one edge after start; MUL keeps busy high for
// WIDTH cycles, then pulses done together with the full 2*WIDTH product.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Operation encoding inherited from the 1-bit ALU slice
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     mcand_reg, mcand_next;      // multiplicand A
  logic [2*WIDTH-1:0]   acc_reg, acc_next;          // {partial hi, multiplier/product lo}
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [WIDTH-1:0]     result_reg, result_next;
  logic [WIDTH-1:0]     result_hi_reg, result_hi_next;
  logic                 zero_reg, zero_next;
  logic                 cout_reg, cout_next;
  logic                 overflow_reg, overflow_next;
  logic                 done_reg, done_next;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH-1:0] and_bits, or_bits, nor_bits;
  logic [WIDTH:0]   add_full, sub_full;
  logic             add_ovf, sub_ovf, slt_less;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ovf;

  // Bitwise unit built as a row of the original 1-bit logic slices
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign and_bits[gi] = src1[gi] & src2[gi];
      assign or_bits[gi]  = src1[gi] | src2[gi];
      assign nor_bits[gi] = ~(src1[gi] | src2[gi]);
    end
  endgenerate

  // SUB is A + ~B + 1 so its carry out means "no borrow"
  assign add_full = {1'b0, src1} + {1'b0, src2};
  assign sub_full = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf  = (src1[WIDTH-1] == src2[WIDTH-1]) && (add_full[WIDTH-1] != src1[WIDTH-1]);
  assign sub_ovf  = (src1[WIDTH-1] != src2[WIDTH-1]) && (sub_full[WIDTH-1] != src1[WIDTH-1]);
  // Signed less-than: difference sign corrected by overflow
  assign slt_less = sub_full[WIDTH-1] ^ sub_ovf;

  // Select the single-cycle result and flags for the requested operation
  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (operation)
      OP_AND: alu_res = and_bits;
      OP_OR:  alu_res = or_bits;
      OP_ADD: begin
        alu_res  = add_full[WIDTH-1:0];
        alu_cout = add_full[WIDTH];
        alu_ovf  = add_ovf;
      end
      OP_SUB: begin
        alu_res  = sub_full[WIDTH-1:0];
        alu_cout = sub_full[WIDTH];
        alu_ovf  = sub_ovf;
      end
      OP_NOR: alu_res = nor_bits;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_less};
      default: alu_res = '0;  // NOP (MUL handled by the FSM)
    endcase
  end

  // ---------------- shift-add multiplier step ----------------
  // Add A into the upper half when the current multiplier bit is set,
  // then shift the whole accumulator right by one.
  logic [WIDTH:0]     hi_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic               mul_last;

  assign hi_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (acc_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
  assign acc_step = {hi_sum, acc_reg[WIDTH-1:1]};
  assign mul_last = (cnt_reg == CW'(WIDTH - 1));

  // Next-state and output-register logic for IDLE/MUL control
  always_comb begin
    state_next     = state_reg;
    mcand_next     = mcand_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    result_next    = result_reg;
    result_hi_next = result_hi_reg;
    zero_next      = zero_reg;
    cout_next      = cout_reg;
    overflow_next  = overflow_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (operation == OP_MUL) begin
            mcand_next = src1;
            acc_next   = {{WIDTH{1'b0}}, src2};
            cnt_next   = '0;
            state_next = MUL;
          end else begin
            result_next    = alu_res;
            result_hi_next = '0;
            zero_next      = (alu_res == '0);
            cout_next      = alu_cout;
            overflow_next  = alu_ovf;
            done_next      = 1'b1;
          end
        end
      end
      MUL: begin
        acc_next = acc_step;
        cnt_next = cnt_reg + CW'(1);
        if (mul_last) begin
          // Product becomes visible only on completion
          result_next    = acc_step[WIDTH-1:0];
          result_hi_next = acc_step[2*WIDTH-1:WIDTH];
          zero_next      = (acc_step == '0);
          cout_next      = 1'b0;
          overflow_next  = 1'b0;
          done_next      = 1'b1;
          cnt_next       = '0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset aborts any multiply in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mcand_reg     <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b0;
      cout_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mcand_reg     <= mcand_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      result_reg    <= result_next;
      result_hi_reg <= result_hi_next;
      zero_reg      <= zero_next;
      cout_reg      <= cout_next;
      overflow_reg  <= overflow_next;
      done_reg      <= done_next;
    end
  end

  assign busy      = (state_reg == MUL);
  assign done      = done_reg;
  assign result    = result_reg;
  assign result_hi = result_hi_reg;
  assign zero      = zero_reg;
  assign cout      = cout_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=8: table of single-cycle vectors
// plus hand-written multiply, mid-multiply reset and back-to-back sequences.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   operation;
  logic [W-1:0] src1, src2;
  logic         busy, done, zero, cout, overflow;
  logic [W-1:0] result, result_hi;

  int tests  = 0;
  int failed = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operation (operation),
    .src1      (src1),
    .src2      (src2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
  } vec_t;

  vec_t vecs [11];

  // Packed view of all outputs: {done,busy,result_hi,result,zero,cout,overflow}
  function automatic logic [20:0] outs();
    return {done, busy, result_hi, result, zero, cout, overflow};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int bc;
  logic [W-1:0] prev_res, prev_hi;
  logic held_ok;

  initial begin
    vecs[0]  = '{3'b011, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1}; // ADD overflow
    vecs[1]  = '{3'b100, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0}; // SUB equal
    vecs[2]  = '{3'b100, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0}; // SUB borrow
    vecs[3]  = '{3'b110, 8'hFE, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0}; // SLT -2<1
    vecs[4]  = '{3'b110, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0}; // SLT with ovf
    vecs[5]  = '{3'b101, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0}; // NOR
    vecs[6]  = '{3'b001, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0}; // AND
    vecs[7]  = '{3'b010, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0}; // OR
    vecs[8]  = '{3'b011, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0}; // ADD carry wrap
    vecs[9]  = '{3'b100, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1}; // SUB overflow
    vecs[10] = '{3'b000, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0}; // NOP

    rst = 1'b1; start = 1'b0; operation = 3'b000; src1 = '0; src2 = '0;
    tick(); tick();
    check("reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven single-cycle operations
    for (int i = 0; i < 11; i++) begin
      start = 1'b1; operation = vecs[i].op; src1 = vecs[i].a; src2 = vecs[i].b;
      tick();
      start = 1'b0; src1 = ~src1; src2 = ~src2;  // operands changing afterwards must not matter
      check($sformatf("vec%0d_op%0d_%h_%h", i, vecs[i].op, vecs[i].a, vecs[i].b), 32'(outs()),
            32'({1'b1, 1'b0, 8'h00, vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].v}));
      tick();
      check($sformatf("vec%0d_done_drop", i), 32'(done), 32'd0);
    end

    // MUL FF*FF with an ignored ADD start pulsed mid-multiply
    prev_res = result; prev_hi = result_hi;
    start = 1'b1; operation = 3'b111; src1 = 8'hFF; src2 = 8'hFF;
    tick();
    start = 1'b0; src1 = 8'h01; src2 = 8'h01;
    bc = 0; held_ok = 1'b1;
    while (busy && bc < 20) begin
      bc++;
      if (done || result !== prev_res || result_hi !== prev_hi) held_ok = 1'b0;
      if (bc == 3) begin start = 1'b1; operation = 3'b011; end
      else start = 1'b0;
      tick();
    end
    start = 1'b0;
    check("mul_ff_busy_cycles", 32'(bc), 32'd8);
    check("mul_ff_outputs_held", 32'(held_ok), 32'd1);
    check("mul_ff_result", 32'(outs()), 32'({1'b1, 1'b0, 8'hFE, 8'h01, 1'b0, 1'b0, 1'b0}));
    tick();
    check("mul_ff_done_drop", 32'({done, busy}), 32'd0);

    // Reset on the 4th busy cycle of MUL 03*05
    start = 1'b1; operation = 3'b111; src1 = 8'h03; src2 = 8'h05;
    tick();
    start = 1'b0;
    bc = 0;
    while (busy && bc < 4) begin
      bc++;
      if (bc == 4) rst = 1'b1;
      tick();
    end
    check("mul_rst_busy_seen", 32'(bc), 32'd4);
    check("mul_rst_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
    tick();
    check("mul_rst_no_done", 32'({done, busy}), 32'd0);

    // Fresh MUL 03*05 after the abort
    start = 1'b1; operation = 3'b111; src1 = 8'h03; src2 = 8'h05;
    tick();
    start = 1'b0;
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      tick();
    end
    check("mul_35_busy_cycles", 32'(bc), 32'd8);
    check("mul_35_result", 32'(outs()), 32'({1'b1, 1'b0, 8'h00, 8'h0F, 1'b0, 1'b0, 1'b0}));

    // start held high across three consecutive ADDs (first issued in the done cycle)
    start = 1'b1; operation = 3'b011;
    for (int k = 1; k <= 3; k++) begin
      src1 = 8'(k); src2 = 8'(k);
      tick();
      check($sformatf("b2b_add%0d", k), 32'({done, busy, result}), 32'({1'b1, 1'b0, 8'(2 * k)}));
    end
    start = 1'b0;
    tick();
    check("b2b_done_drop", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
